// File: rtl/alu_1bit.sv
// One-bit MIPS ALU slice: logical ops plus full-adder ADD/SUB, with a
// combinational result/carry and an enable-gated registered copy of both.
module alu_1bit (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic carry_in,
  input  logic op2,
  input  logic op1,
  input  logic op0,
  input  logic en,
  output logic result,
  output logic carry_out,
  output logic result_r,
  output logic carry_out_r
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_NOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_SUB  = 3'b110,
    OP_XNOR = 3'b111
  } op_e;

  op_e  w_op;
  logic w_bx;
  logic w_sum;
  logic w_cout;
  logic w_result;
  logic w_carry;
  logic r_result;
  logic r_carry;

  assign w_op = op_e'({op2, op1, op0});

  // op2 doubles as the B-invert control, so SUB is ADD of ~b with cin=1 at bit 0
  assign w_bx   = b ^ op2;
  assign w_sum  = a ^ w_bx ^ carry_in;
  assign w_cout = (a & w_bx) | (a & carry_in) | (w_bx & carry_in);

  always_comb begin
    w_result = 1'b0;
    w_carry  = 1'b0;
    case (w_op)
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_ADD: begin
        w_result = w_sum;
        w_carry  = w_cout;
      end
      OP_XOR:  w_result = a ^ b;
      OP_NOR:  w_result = ~(a | b);
      OP_NAND: w_result = ~(a & b);
      OP_SUB: begin
        w_result = w_sum;
        w_carry  = w_cout;
      end
      OP_XNOR: w_result = ~(a ^ b);
      default: begin
        w_result = 1'b0;
        w_carry  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 1'b0;
      r_carry  <= 1'b0;
    end else if (en) begin
      r_result <= w_result;
      r_carry  <= w_carry;
    end
  end

  assign result      = w_result;
  assign carry_out   = w_carry;
  assign result_r    = r_result;
  assign carry_out_r = r_carry;

endmodule

// File: tb/tb_alu_1bit.sv
// Directed self-checking bench for alu_1bit: combinational opcode table
// and the reset/enable behaviour of the registered outputs.
module tb_alu_1bit;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic carry_in;
  logic op2;
  logic op1;
  logic op0;
  logic en;
  logic result;
  logic carry_out;
  logic result_r;
  logic carry_out_r;

  int checks;
  int errors;

  alu_1bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .op2         (op2),
    .op1         (op1),
    .op0         (op0),
    .en          (en),
    .result      (result),
    .carry_out   (carry_out),
    .result_r    (result_r),
    .carry_out_r (carry_out_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic comb(input string name, input logic [2:0] op, input logic ia,
                      input logic ib, input logic icin, input logic exp_r,
                      input logic exp_c);
    {op2, op1, op0} = op;
    a = ia;
    b = ib;
    carry_in = icin;
    #1;
    check($sformatf("%s a=%b b=%b cin=%b result", name, ia, ib, icin), result, exp_r);
    check($sformatf("%s a=%b b=%b cin=%b carry_out", name, ia, ib, icin), carry_out, exp_c);
    $display("op=%b a=%b b=%b cin=%b -> result=%b carry_out=%b", op, ia, ib, icin,
             result, carry_out);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    carry_in = 1'b0;
    {op2, op1, op0} = 3'b000;

    // Reset state, asserted from time 0
    #2;
    check("reset result_r", result_r, 1'b0);
    check("reset carry_out_r", carry_out_r, 1'b0);

    // AND / OR / XOR sweep, carry_in both values; results must not change
    for (int c = 0; c < 2; c++) begin
      comb("AND", 3'b000, 0, 0, c[0], 0, 0);
      comb("AND", 3'b000, 1, 1, c[0], 1, 0);
      comb("AND", 3'b000, 1, 0, c[0], 0, 0);
      comb("AND", 3'b000, 0, 1, c[0], 0, 0);
      comb("OR",  3'b001, 0, 0, c[0], 0, 0);
      comb("OR",  3'b001, 1, 1, c[0], 1, 0);
      comb("OR",  3'b001, 1, 0, c[0], 1, 0);
      comb("OR",  3'b001, 0, 1, c[0], 1, 0);
      comb("XOR", 3'b011, 0, 0, c[0], 0, 0);
      comb("XOR", 3'b011, 1, 1, c[0], 0, 0);
      comb("XOR", 3'b011, 1, 0, c[0], 1, 0);
      comb("XOR", 3'b011, 0, 1, c[0], 1, 0);
    end

    // ADD
    comb("ADD", 3'b010, 0, 0, 0, 0, 0);
    comb("ADD", 3'b010, 1, 1, 0, 0, 1);
    comb("ADD", 3'b010, 1, 0, 0, 1, 0);
    comb("ADD", 3'b010, 0, 1, 0, 1, 0);
    comb("ADD", 3'b010, 1, 1, 1, 1, 1);
    comb("ADD", 3'b010, 0, 1, 1, 0, 1);
    comb("ADD", 3'b010, 0, 0, 1, 1, 0);

    // SUB (bx = ~b)
    comb("SUB", 3'b110, 0, 0, 1, 0, 1);
    comb("SUB", 3'b110, 1, 0, 1, 1, 1);
    comb("SUB", 3'b110, 0, 1, 1, 1, 0);
    comb("SUB", 3'b110, 1, 1, 1, 0, 1);
    comb("SUB", 3'b110, 0, 0, 0, 1, 0);
    comb("SUB", 3'b110, 1, 0, 0, 0, 1);

    // NOR / NAND / XNOR
    comb("NOR",  3'b100, 0, 0, 1, 1, 0);
    comb("NOR",  3'b100, 1, 1, 1, 0, 0);
    comb("NOR",  3'b100, 1, 0, 0, 0, 0);
    comb("NOR",  3'b100, 0, 1, 0, 0, 0);
    comb("NAND", 3'b101, 0, 0, 1, 1, 0);
    comb("NAND", 3'b101, 1, 1, 1, 0, 0);
    comb("NAND", 3'b101, 1, 0, 0, 1, 0);
    comb("NAND", 3'b101, 0, 1, 0, 1, 0);
    comb("XNOR", 3'b111, 0, 0, 1, 1, 0);
    comb("XNOR", 3'b111, 1, 1, 1, 1, 0);
    comb("XNOR", 3'b111, 1, 0, 0, 0, 0);
    comb("XNOR", 3'b111, 0, 1, 0, 0, 0);

    // Registered path: reset still held, so a capture must not happen
    en = 1'b1;
    {op2, op1, op0} = 3'b010;
    a = 1'b1;
    b = 1'b1;
    carry_in = 1'b0;
    @(posedge clk);
    #1;
    check("held-in-reset result_r", result_r, 1'b0);
    check("held-in-reset carry_out_r", carry_out_r, 1'b0);

    // Release reset away from the edge, then capture ADD 1+1
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("capture ADD result_r", result_r, 1'b0);
    check("capture ADD carry_out_r", carry_out_r, 1'b1);
    $display("capture: result_r=%b carry_out_r=%b", result_r, carry_out_r);

    // Hold with en=0 while inputs change to OR 1|0
    en = 1'b0;
    {op2, op1, op0} = 3'b001;
    a = 1'b1;
    b = 1'b0;
    @(posedge clk);
    #1;
    check("hold result_r", result_r, 1'b0);
    check("hold carry_out_r", carry_out_r, 1'b1);
    @(posedge clk);
    #1;
    check("hold2 result_r", result_r, 1'b0);
    check("hold2 carry_out_r", carry_out_r, 1'b1);
    $display("hold: result_r=%b carry_out_r=%b", result_r, carry_out_r);

    // Re-enable: update on the next edge
    en = 1'b1;
    @(posedge clk);
    #1;
    check("update result_r", result_r, 1'b1);
    check("update carry_out_r", carry_out_r, 1'b0);
    $display("update: result_r=%b carry_out_r=%b", result_r, carry_out_r);

    // Load carry=1 again, then assert reset mid-cycle
    {op2, op1, op0} = 3'b010;
    a = 1'b1;
    b = 1'b1;
    @(posedge clk);
    #1;
    check("reload carry_out_r", carry_out_r, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset result_r", result_r, 1'b0);
    check("async reset carry_out_r", carry_out_r, 1'b0);
    $display("async reset: result_r=%b carry_out_r=%b", result_r, carry_out_r);

    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
